// File: rtl/ram_fifo_pkg.sv
// Shared constants and FSM state type for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_CAP  = 2'd2
  } state_e;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping W-bit pointer with increment enable; used for both FIFO pointers.
module ram_fifo_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ptr <= '0;
    end else if (i_inc) begin
      o_ptr <= o_ptr + W'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external single-port synchronous RAM.
// Define RAM_FIFO_ERR_EN to build in the sticky misuse detector on o_err.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_W = ram_fifo_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram_fifo_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push_valid,
  input  logic [DATA_W-1:0] i_push_data,
  output logic              o_push_ready,
  input  logic              i_pop_req,
  output logic              o_pop_valid,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_ram_write_en,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_write_data,
  input  logic [DATA_W-1:0] i_ram_read_data,
  output logic              o_err
);

  import ram_fifo_pkg::*;

  localparam int unsigned CNT_BITS   = ADDR_W + 1;
  localparam int unsigned FIFO_DEPTH = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0]   pop_data_q, pop_data_d;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic                push_ready_c;
  logic                push_acc, pop_acc;

  // Pop wins over a simultaneous push, so push is only offered when no pop is taken.
  assign push_ready_c = (state_q == IDLE) & ~full_q & ~(i_pop_req & ~empty_q);

  ram_fifo_ptr #(.W(ADDR_W)) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (push_acc),
    .o_ptr   (wr_ptr)
  );

  ram_fifo_ptr #(.W(ADDR_W)) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (pop_acc),
    .o_ptr   (rd_ptr)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pop_valid_d = 1'b0;
    pop_data_d  = pop_data_q;
    pop_acc     = 1'b0;
    push_acc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        pop_acc  = i_pop_req & ~empty_q;
        push_acc = i_push_valid & push_ready_c;
        if (pop_acc) begin
          state_d = RD_ADDR;
          addr_d  = rd_ptr;
          count_d = count_q - CNT_BITS'(1);
        end else if (push_acc) begin
          we_d    = 1'b1;
          addr_d  = wr_ptr;
          wdata_d = i_push_data;
          count_d = count_q + CNT_BITS'(1);
        end
      end
      RD_ADDR: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        // RAM output now reflects the address presented during RD_ADDR.
        state_d     = IDLE;
        pop_valid_d = 1'b1;
        pop_data_d  = i_ram_read_data;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    full_d  = (count_d == CNT_BITS'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

`ifdef RAM_FIFO_ERR_EN
  logic err_q;

  // Sticky until reset: push into full, or pop from empty while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if ((i_push_valid & full_q) | (i_pop_req & empty_q & (state_q == IDLE))) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_push_ready     = push_ready_c;
  assign o_pop_valid      = pop_valid_q;
  assign o_pop_data       = pop_data_q;
  assign o_full           = full_q;
  assign o_empty          = empty_q;
  assign o_count          = count_q;
  assign o_ram_write_en   = we_q;
  assign o_ram_addr       = addr_q;
  assign o_ram_write_data = wdata_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a synchronous-read 8x4 RAM model.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push_valid = 1'b0;
  logic [3:0] push_data = 4'd0;
  logic       push_ready;
  logic       pop_req = 1'b0;
  logic       pop_valid;
  logic [3:0] pop_data;
  logic       full, empty;
  logic [3:0] count;
  logic       ram_we;
  logic [2:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata = 4'd0;
  logic       err;

`ifdef RAM_FIFO_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {
    int         due;
    logic [2:0] addr;
    logic [3:0] data;
  } wexp_t;

  typedef struct {
    int         due;
    logic [3:0] data;
  } pexp_t;

  wexp_t wq[$];
  pexp_t pq[$];
  logic [3:0] mem [8];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  ram_fifo_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_push_valid     (push_valid),
    .i_push_data      (push_data),
    .o_push_ready     (push_ready),
    .i_pop_req        (pop_req),
    .o_pop_valid      (pop_valid),
    .o_pop_data       (pop_data),
    .o_full           (full),
    .o_empty          (empty),
    .o_count          (count),
    .o_ram_write_en   (ram_we),
    .o_ram_addr       (ram_addr),
    .o_ram_write_data (ram_wdata),
    .i_ram_read_data  (ram_rdata),
    .o_err            (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, registered read (read-before-write).
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: every cycle, RAM writes and pop pulses must match the scoreboard exactly.
  always @(negedge clk) begin
    if (wq.size() > 0 && wq[0].due == cyc) begin
      wexp_t w;
      w = wq.pop_front();
      chk("wr_en", 32'(ram_we), 32'd1);
      chk("wr_addr", 32'(ram_addr), 32'(w.addr));
      chk("wr_data", 32'(ram_wdata), 32'(w.data));
    end else begin
      chk("no_write", 32'(ram_we), 32'd0);
    end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      pexp_t p;
      p = pq.pop_front();
      chk("pop_valid", 32'(pop_valid), 32'd1);
      chk("pop_data", 32'(pop_data), 32'(p.data));
    end else begin
      chk("no_pop_valid", 32'(pop_valid), 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      push_valid = 1'b0;
      pop_req    = 1'b0;
    end
  endtask

  task automatic push(input logic [3:0] d, input logic acc, input logic [2:0] a);
    @(negedge clk);
    pop_req    = 1'b0;
    push_valid = 1'b1;
    push_data  = d;
    #1;
    chk("push_ready", 32'(push_ready), 32'(acc));
    if (acc) wq.push_back('{due: cyc + 1, addr: a, data: d});
  endtask

  task automatic pop(input logic acc, input logic [3:0] d);
    @(negedge clk);
    push_valid = 1'b0;
    pop_req    = 1'b1;
    #1;
    if (acc) pq.push_back('{due: cyc + 3, data: d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    push_valid = 1'b0;
    pop_req    = 1'b0;
    wq.delete();
    pq.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_push_ready", 32'(push_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    do_reset();

    // Three pushes land at addresses 0..2, then drain in order.
    push(4'd7, 1'b1, 3'd0);
    push(4'd3, 1'b1, 3'd1);
    push(4'd5, 1'b1, 3'd2);
    idle(1);
    chk("count_3", 32'(count), 32'd3);
    pop(1'b1, 4'd7); idle(2);
    pop(1'b1, 4'd3); idle(2);
    pop(1'b1, 4'd5); idle(2);
    idle(1);
    chk("empty_after_pops", 32'(empty), 32'd1);
    chk("count_0", 32'(count), 32'd0);

    // Fill to 8, reject a 9th, then pop one and refill through the wrap.
    do_reset();
    for (int i = 0; i < 8; i++) push(4'(i + 1), 1'b1, 3'(i));
    idle(1);
    chk("full_8", 32'(full), 32'd1);
    chk("count_8", 32'(count), 32'd8);
    chk("ready_when_full", 32'(push_ready), 32'd0);
    push(4'd9, 1'b0, 3'd0);
    idle(1);
    chk("count_after_9th", 32'(count), 32'd8);
    pop(1'b1, 4'd1); idle(2);
    push(4'd10, 1'b1, 3'd0);
    idle(1);
    chk("count_refill", 32'(count), 32'd8);
    chk("full_refill", 32'(full), 32'd1);

    // Drain down to two words: 8 at addr 7, 10 at addr 0.
    for (int i = 0; i < 6; i++) begin
      pop(1'b1, 4'(i + 2));
      idle(2);
    end
    idle(1);
    chk("count_2", 32'(count), 32'd2);

    // Simultaneous push/pop: pop wins, push waits until the FSM is idle again.
    @(negedge clk);
    pop_req = 1'b1; push_valid = 1'b1; push_data = 4'd11;
    #1;
    chk("ready_pop_prio", 32'(push_ready), 32'd0);
    pq.push_back('{due: cyc + 3, data: 4'd8});
    repeat (2) begin
      @(negedge clk);
      pop_req = 1'b0;
      #1;
      chk("ready_busy", 32'(push_ready), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("ready_n3", 32'(push_ready), 32'd1);
    wq.push_back('{due: cyc + 1, addr: 3'd1, data: 4'd11});
    idle(1);
    chk("count_2_after", 32'(count), 32'd2);
    pop(1'b1, 4'd10); idle(2);
    pop(1'b1, 4'd11); idle(2);
    idle(1);
    chk("empty_after_wrap", 32'(empty), 32'd1);

    // Reset while in RD_CAP aborts the read with no pulse.
    push(4'd12, 1'b1, 3'd2);
    idle(1);
    @(negedge clk);
    push_valid = 1'b0; pop_req = 1'b1;
    idle(1);
    do_reset();
    idle(3);
    chk("count_after_abort", 32'(count), 32'd0);

    // Pop on empty: ignored; flags o_err only when the detector is built in.
    pop(1'b0, 4'd0);
    idle(1);
    chk("err_set", 32'(err), 32'(ERR_ON));
    idle(2);
    chk("err_sticky", 32'(err), 32'(ERR_ON));
    chk("empty_after_misuse", 32'(empty), 32'd1);
    do_reset();

    // Pop right after a push returns the freshly written word.
    push(4'd13, 1'b1, 3'd0);
    pop(1'b1, 4'd13);
    idle(3);
    chk("empty_final", 32'(empty), 32'd1);

    idle(2);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("pq_drained", 32'(pq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The interface SHALL use one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
REQ-002 Parameter DATA_W SHALL default to 4: data width, matching the RAM word.
REQ-003 Parameter ADDR_W SHALL default to 3: RAM address width; depth is 2**ADDR_W = 8.
REQ-004 Port i_clk, input, 1: rising-edge clock.
REQ-005 Port i_rst_n, input, 1: async active-low reset.
REQ-006 Port i_push_valid, input, 1: producer offers i_push_data.
REQ-007 Port i_push_data, input, DATA_W: word to enqueue.
REQ-008 Port o_push_ready, output, 1: a push is accepted this cycle when i_push_valid is also high.
REQ-009 Port i_pop_req, input, 1: consumer requests one word.
REQ-010 Port o_pop_valid, output, 1: one-cycle pulse qualifying o_pop_data.
REQ-011 Port o_pop_data, output, DATA_W: dequeued word, held until the next pop completes.
REQ-012 Port o_full, output, 1: count == 8.
REQ-013 Port o_empty, output, 1: count == 0.
REQ-014 Port o_count, output, ADDR_W+1: number of stored words, 0..8.
REQ-015 Ports o_ram_write_en (output, 1), o_ram_addr (output, ADDR_W), o_ram_write_data (output, DATA_W) and i_ram_read_data (input, DATA_W) SHALL drive and read the downstream single-port 8x4 ram.
REQ-016 Port o_err, output, 1: sticky misuse flag, per REQ-031.

Function
REQ-017 The FSM SHALL have three states, IDLE, RD_ADDR and RD_CAP, and all RAM-side outputs SHALL be registered.
REQ-018 A pop SHALL be accepted in cycle N when the state is IDLE, i_pop_req is high and o_empty is low; a pop has priority over a simultaneous push.
REQ-019 o_push_ready SHALL equal (state==IDLE) & ~o_full & ~(i_pop_req & ~o_empty), as a combinational signal.
REQ-020 On push accept in cycle N: in cycle N+1, o_ram_write_en is 1 for exactly one cycle, o_ram_addr is wr_ptr and o_ram_write_data is the accepted data; wr_ptr increments and o_count increments at the end of cycle N.
REQ-021 On pop accept in cycle N: in cycles N+1 (RD_ADDR) and N+2 (RD_CAP), o_ram_addr is held at rd_ptr with o_ram_write_en at 0; at the end of N+2, i_ram_read_data is captured into o_pop_data; o_pop_valid is 1 in cycle N+3 only; the state returns to IDLE in N+3.
REQ-022 o_count SHALL decrement and rd_ptr SHALL increment at the end of pop-accept cycle N.
REQ-023 Both pointers SHALL wrap from 7 to 0.
REQ-024 A push with o_full high SHALL be ignored, with no RAM write and no count change.
REQ-025 A pop request with o_empty high or while not in IDLE SHALL be ignored.
REQ-026 A word pushed in cycle N SHALL be poppable from cycle N+1, because its RAM write completes before the read address is presented.

Reset
REQ-027 While i_rst_n is low: state IDLE, pointers 0, o_count 0, o_empty 1, o_full 0, o_pop_valid 0, o_pop_data 0, o_ram_write_en 0, o_ram_addr 0, o_ram_write_data 0, o_err 0.
REQ-028 A reset during RD_ADDR or RD_CAP SHALL abort the read, with no o_pop_valid pulse; stored contents are logically discarded.
REQ-029 After reset is released, o_push_ready SHALL be 1 while i_pop_req is low.

Configuration
REQ-030 Macro RAM_FIFO_ERR_EN SHALL compile the error detector in or out.
REQ-031 With RAM_FIFO_ERR_EN defined: o_err is set at the end of any cycle with (i_push_valid & o_full) or (i_pop_req & o_empty & state==IDLE), and it clears only on reset. Without the macro, o_err is tied to 0.

Structure
REQ-032 Package ram_fifo_pkg SHALL hold DATA_W=4, ADDR_W=3, DEPTH=8, CNT_W=4 and the state enum {IDLE, RD_ADDR, RD_CAP}.
REQ-033 Sub-module ram_fifo_ptr SHALL be a wrapping ADDR_W-bit counter with increment enable and async active-low reset, instantiated once for wr_ptr and once for rd_ptr.

Verification
REQ-034 Reset: pulse i_rst_n low for 2 cycles -> o_empty=1, o_count=0, o_ram_write_en=0, o_push_ready=1.
REQ-035 Push 7, 3, 5 on consecutive cycles -> write pulses at addr 0/1/2 with data 7/3/5, then o_count=3.
REQ-036 Three pops -> o_pop_data = 7, 3, 5, each with o_pop_valid 3 cycles after acceptance; o_empty=1 at the end.
REQ-037 Push 8 words -> o_full=1 and o_push_ready=0; a 9th push is ignored; one pop followed by one push -> write at addr 0 (wrap), o_count=8.
REQ-038 With o_count=2, push and pop in the same cycle -> pop accepted, push held off; the push is accepted at N+3, o_count=2 afterwards.
REQ-039 Reset asserted in RD_CAP -> no o_pop_valid pulse, o_count=0; with RAM_FIFO_ERR_EN, a pop on empty -> o_err=1 until reset.
